// File: rtl/fetch_icache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache and req/ack refill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module fetch_icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    output logic [15:0] address_out,
    output logic [15:0] instruction_out,
    output logic        hit_out,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 15 - INDEX_BITS;

    typedef enum logic {LOOKUP, FILL} state_t;

    state_t                state_reg, state_next;
    logic [15:0]           pc_reg, pc_next;
    logic                  mem_req_reg, mem_req_next;
    logic [15:0]           mem_addr_reg, mem_addr_next;
    logic [LINES-1:0]      valid_reg;
    logic [TAG_BITS-1:0]   tag_mem [LINES];
    logic [15:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  line_hit;
    logic                  fill_done;

    assign idx         = pc_reg[INDEX_BITS:1];
    assign pc_tag      = pc_reg[15:INDEX_BITS+1];
    assign line_hit    = valid_reg[idx] && (tag_mem[idx] == pc_tag);
    assign address_out = pc_reg + 16'd2;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        hit_out         = 1'b0;
        instruction_out = 16'h0000;
        fill_done       = 1'b0;
        case (state_reg)
            LOOKUP: begin
                if (line_hit) begin
                    hit_out         = 1'b1;
                    instruction_out = data_mem[idx];
                    pc_next         = pc_src ? (branch_target & 16'hFFFE) : (pc_reg + 16'd2);
                end else begin
                    state_next    = FILL;
                    mem_req_next  = 1'b1;
                    mem_addr_next = {pc_reg[15:1], 1'b0};
                end
            end
            FILL: begin
                // PC is frozen during the fill, so idx/pc_tag still name the line being refilled.
                if (mem_ack) begin
                    fill_done    = 1'b1;
                    mem_req_next = 1'b0;
                    state_next   = LOOKUP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LOOKUP;
            pc_reg       <= 16'h0000;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_done && (idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_done && !rst) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= pc_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= 16'h0000;
            miss_count_reg <= 16'h0000;
        end else begin
            if (hit_out && (hit_count_reg != 16'hFFFF)) begin
                hit_count_reg <= hit_count_reg + 16'd1;
            end
            if ((state_reg == LOOKUP) && !line_hit && (miss_count_reg != 16'hFFFF)) begin
                miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_fetch_icache.sv
// Scoreboard bench for fetch_icache: fetch stimulus pushes expected {address_out, instruction},
// a negedge monitor pops and compares on every hit; a behavioural memory answers refills.
module tb_fetch_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [15:0] branch_target;
    logic [15:0] address_out;
    logic [15:0] instruction_out;
    logic        hit_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    fetch_icache #(.INDEX_BITS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .address_out     (address_out),
        .instruction_out (instruction_out),
        .hit_out         (hit_out),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic mon_en = 1'b1;

    // Memory model: acks in the ack_delay-th cycle that mem_req is seen high.
    logic        mem_auto = 1'b1;
    logic        manual_ack = 1'b0;
    logic [15:0] manual_data = 16'h0000;
    logic        auto_ack = 1'b0;
    logic [15:0] auto_data = 16'h0000;
    int          ack_delay = 1;
    int          req_cycles = 0;

    assign mem_ack   = mem_auto ? auto_ack  : manual_ack;
    assign mem_rdata = mem_auto ? auto_data : manual_data;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'h2002;
            16'h0004: return 16'h2004;
            16'h0006: return 16'h2006;
            16'h0008: return 16'h2008;
            16'h000A: return 16'h200A;
            16'h000C: return 16'h200C;
            16'h000E: return 16'h200E;
            16'h0020: return 16'hBEEF;
            16'h0030: return 16'h3030;
            16'h0040: return 16'h4040;
            16'hFFFE: return 16'hFFEE;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || !mem_auto || !mem_req) begin
            req_cycles <= 0;
            auto_ack   <= 1'b0;
        end else if (req_cycles + 1 >= ack_delay) begin
            req_cycles <= 0;
            auto_ack   <= 1'b1;
            auto_data  <= mem_word(mem_addr);
        end else begin
            req_cycles <= req_cycles + 1;
            auto_ack   <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en && hit_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit actual=%h required=no_hit", address_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_address_out", address_out, e[31:16]);
                chk("sb_instruction", instruction_out, e[15:0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that consumed the hit.
    task automatic fetch(input logic [15:0] pc, input logic [15:0] instr, input logic take,
                         input logic [15:0] tgt, input int exp_stalls);
        int  stalls;
        bit  first;
        bit  req_seen;
        pc_src        = take;
        branch_target = tgt;
        exp_q.push_back({pc + 16'd2, instr});
        stalls   = 0;
        first    = 1'b1;
        req_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (first) chk("pc_now", address_out, pc + 16'd2);
            first = 1'b0;
            if (mem_req && !req_seen) begin
                chk("mem_addr", mem_addr, {pc[15:1], 1'b0});
                req_seen = 1'b1;
            end
            if (hit_out) break;
            stalls++;
            if (stalls > 40) begin
                $display("FAIL fetch_timeout actual=no_hit required=hit pc=%h", pc);
                $fatal(1, "fetch timeout");
            end
        end
        chk("stalls", 16'(stalls), 16'(exp_stalls));
        $display("fetch pc=%h instr=%h stalls=%0d take=%0d tgt=%h", pc, instruction_out, stalls, take, tgt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] hc0;
        bit          got_req;
        rst           = 1'b1;
        pc_src        = 1'b0;
        branch_target = 16'h0000;
        hc0           = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_address_out", address_out, 16'h0002);
        chk("rst_hit_out", 16'(hit_out), 16'h0000);
        chk("rst_instruction", instruction_out, 16'h0000);
        chk("rst_mem_req", 16'(mem_req), 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 16'h0000);
        chk("rst_miss_count", miss_count, 16'h0000);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First pass: every word misses.
        ack_delay = 3;
        fetch(16'h0000, 16'h1234, 1'b0, 16'h0000, 4);
        ack_delay = 1;
        fetch(16'h0002, 16'h2002, 1'b0, 16'h0000, 2);
        fetch(16'h0004, 16'h2004, 1'b0, 16'h0000, 2);
        fetch(16'h0006, 16'h2006, 1'b0, 16'h0000, 2);
        fetch(16'h0008, 16'h2008, 1'b0, 16'h0000, 2);
        fetch(16'h000A, 16'h200A, 1'b0, 16'h0000, 2);
        fetch(16'h000C, 16'h200C, 1'b0, 16'h0000, 2);
        fetch(16'h000E, 16'h200E, 1'b1, 16'h0000, 2);

        // Second pass: all hits.
`ifdef ICACHE_STATS_EN
        hc0 = hit_count;
`endif
        fetch(16'h0000, 16'h1234, 1'b0, 16'h0000, 0);
        fetch(16'h0002, 16'h2002, 1'b0, 16'h0000, 0);
        fetch(16'h0004, 16'h2004, 1'b0, 16'h0000, 0);
        fetch(16'h0006, 16'h2006, 1'b0, 16'h0000, 0);
        fetch(16'h0008, 16'h2008, 1'b0, 16'h0000, 0);
        fetch(16'h000A, 16'h200A, 1'b0, 16'h0000, 0);
        fetch(16'h000C, 16'h200C, 1'b0, 16'h0000, 0);
        fetch(16'h000E, 16'h200E, 1'b1, 16'h0020, 0);
`ifdef ICACHE_STATS_EN
        chk("hit_count_delta", hit_count - hc0, 16'd8);
`endif

        // Conflict at index 0, branch-target bit 0 masking, PC wrap.
        fetch(16'h0020, 16'hBEEF, 1'b1, 16'h0000, 2);
        fetch(16'h0000, 16'h1234, 1'b1, 16'h0031, 2);
        fetch(16'h0030, 16'h3030, 1'b1, 16'hFFFE, 2);
        fetch(16'hFFFE, 16'hFFEE, 1'b0, 16'h0000, 2);
        fetch(16'h0000, 16'h1234, 1'b1, 16'h0040, 0);

        // Reset in the middle of the 0x0040 refill, then a stale ack.
        mem_auto = 1'b0;
        pc_src   = 1'b0;
        got_req  = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge clk);
            if (mem_req) got_req = 1'b1;
        end
        chk("fill_req_seen", 16'(got_req), 16'h0001);
        chk("fill_req_addr", mem_addr, 16'h0040);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        manual_ack  = 1'b1;
        manual_data = 16'hDEAD;
        @(negedge clk);
        chk("midfill_mem_req", 16'(mem_req), 16'h0000);
        chk("midfill_hit_out", 16'(hit_out), 16'h0000);
        chk("midfill_pc", address_out, 16'h0002);
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
        @(negedge clk);
        chk("fresh_mem_req", 16'(mem_req), 16'h0001);
        chk("fresh_mem_addr", mem_addr, 16'h0000);
        chk("stale_ack_hit", 16'(hit_out), 16'h0000);
`ifdef ICACHE_STATS_EN
        chk("post_rst_hit_count", hit_count, 16'h0000);
        chk("post_rst_miss_count", miss_count, 16'h0001);
`endif
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        fetch(16'h0000, 16'h1234, 1'b1, 16'h0000, 1);

`ifdef ICACHE_STATS_EN
        // Branch-to-self keeps hitting at 0x0000 long enough to saturate.
        mon_en        = 1'b0;
        pc_src        = 1'b1;
        branch_target = 16'h0000;
        repeat (65540) @(posedge clk);
        #1;
        chk("hit_count_sat", hit_count, 16'hFFFF);
        chk("miss_count_final", miss_count, 16'h0001);
        pc_src = 1'b0;
`endif

        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
